cache_fill_axi_master: RTL and testbench
========================================

# cache_fill_axi_master

Cache-line fill engine between the L1 instruction cache's memory-side port (I_req/I_addr/I_wait/I_out) and the CPU wrapper's AXI4 read-address/read-data channels. One cache miss becomes one line-aligned INCR burst of BURST_LEN 32-bit beats. Each beat goes back to the cache as a one-cycle I_wait=0 strobe with the word on I_out. Only one burst is outstanding at a time, and the engine issues reads only.

## Interface
Parameters:
- AXI_ID, 4'd0, constant ARID value; the expected RID.
- BURST_LEN, 4, beats per line fill; power of two, at most 16.
- LINE_OFF_BITS, 4, byte-offset bits of a line; log2(BURST_LEN*4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- I_req  in  1  fill request from the cache; held high for the whole miss.
- I_addr  in  32  miss address; only bits [31:LINE_OFF_BITS] are used.
- I_write  in  1  must be 0; a 1 is rejected.
- I_in  in  32  unused.
- I_type  in  3  unused; always word.
- I_out  out  32  fill word; valid only when I_wait=0.
- I_wait  out  1  low for exactly one cycle per accepted beat.
- ARID  out  4  equals AXI_ID.
- ARADDR  out  32  line-aligned address.
- ARLEN  out  4  equals BURST_LEN-1.
- ARSIZE  out  3  equals 3'b010.
- ARBURST  out  2  equals 2'b01 (INCR).
- ARVALID  out  1  address valid.
- ARREADY  in  1  address ready.
- RID  in  4  read ID.
- RDATA  in  32  read data.
- RRESP  in  2  read response.
- RLAST  in  1  last beat.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- fill_err  out  1  sticky error flag; cleared only by rst.

## Operation
States:
- IDLE: I_req=1 and I_write=0 → capture line address {I_addr[31:LINE_OFF_BITS], 0}, clear beat_cnt, go to ADDR.
  - I_req=1 and I_write=1 → set fill_err and stay in IDLE. I_wait stays 1, so the cache hangs visibly.
- ADDR: ARVALID=1 with stable ARADDR/ARLEN/ARSIZE/ARBURST. ARVALID=1 and ARREADY=1 → go to DATA. ARVALID never drops before the handshake.
- DATA: RREADY=1. Each RVALID=1 and RID==AXI_ID is one beat:
  - I_out=RDATA and I_wait=0, combinationally, in the same cycle.
  - beat_cnt increments.
  - When beat_cnt==BURST_LEN-1, go to IDLE.
- A beat with RID≠AXI_ID is still accepted (RREADY=1) but is not forwarded: I_wait stays 1, beat_cnt is unchanged, fill_err is set.
- RRESP≠2'b00 on a forwarded beat: forward the beat anyway and set fill_err.
- RLAST mismatch (RLAST=1 before the final beat, or RLAST=0 on the final beat): set fill_err. The burst always ends on beat count, never on RLAST.
- I_req dropping in ADDR or DATA is a cache protocol violation: ignore it and finish the burst.
- beat_cnt width is log2(BURST_LEN); it wraps to 0 when IDLE is entered.

## Timing
Reset values: ARVALID=0, RREADY=0, I_wait=1, I_out=0, ARADDR=0, fill_err=0, state=IDLE, beat_cnt=0.

Latency and handshakes:
- ARVALID is registered: it rises the cycle after IDLE samples I_req=1.
- With ARREADY tied high, first data can be accepted 2 cycles after I_req rises.
- I_wait and I_out follow RVALID with zero cycles of latency.
- After the final beat, the engine is in IDLE on the next edge. The cache drops I_req on that same edge, so no spurious re-request occurs.
- Back-to-back misses: a new I_req can be accepted in the first IDLE cycle.

Boundary conditions:
- rst in any state returns to IDLE the next edge and drops ARVALID/RREADY immediately. An in-flight burst is abandoned; the system resets the interconnect together with this block.
- RVALID held high continuously gives BURST_LEN consecutive I_wait=0 cycles.

## Configuration
- FILL_PERF_CNT_EN defined: adds 32-bit outputs fill_cnt and stall_cnt.
  - fill_cnt increments once per completed burst.
  - stall_cnt increments every cycle state≠IDLE.
  - Both reset to 0 and wrap at 2^32.
- FILL_PERF_CNT_EN undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

## Structure
- Shared package axi_pkg holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00.
  - typedef enum logic [1:0] fill_state_t {IDLE, ADDR, DATA}.
- The block is a single module.
- An optional sub-module, fill_beat_checker, holds the RID/RRESP/RLAST checks and drives fill_err.

## Test plan
- I_addr=0x0000_1238, I_req=1, ARREADY=1, four beats 0xA0..0xA3 with RLAST on beat 4 → ARADDR=0x0000_1230, ARLEN=3, I_wait=0 on exactly 4 cycles carrying 0xA0..0xA3, fill_err=0.
- ARREADY held low for 5 cycles → ARVALID stays 1 with ARADDR stable; data phase starts after the handshake.
- RVALID toggling 1,0,1,0… → I_wait=0 only on RVALID cycles; 4 forwarded beats total; return to IDLE.
- RRESP=2'b10 on beat 2, then RLAST asserted on beat 3 → beats still forwarded; fill_err=1; burst ends after beat 4.
- rst pulsed during DATA after beat 1 → next cycle ARVALID=0, RREADY=0, I_wait=1; a fresh I_req refills the full line.
- FILL_PERF_CNT_EN defined, 3 fills with ARREADY=1 and RVALID=1 → fill_cnt=3, stall_cnt=15 (5 non-IDLE cycles per fill).

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the fill-engine state type.
// Imported by cache_fill_axi_master and fill_beat_checker.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_axi_master_fill_beat_checker.sv
// fill_beat_checker: validates each read beat presented in the data phase and
// keeps the sticky fill_err flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   write_reject  cache issued a write request (never supported)
//   beat_valid    a beat is being accepted (DATA state and RVALID)
//   last_beat     the beat counter is at the final beat of the line
//   rid/rresp/rlast  AXI read-data sideband of the current beat
//   fill_err      sticky error, cleared only by rst
module fill_beat_checker
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_reject,
  input  logic       beat_valid,
  input  logic       last_beat,
  input  logic [3:0] rid,
  input  logic [1:0] rresp,
  input  logic       rlast,
  output logic       fill_err
);

  logic id_ok_c;
  logic id_bad_c;
  logic resp_bad_c;
  logic last_bad_c;
  logic err_set_c;

  // Foreign-ID beats are swallowed; response and RLAST checks only apply to
  // beats that are actually forwarded to the cache.
  always_comb begin
    id_ok_c    = (rid == AXI_ID);
    id_bad_c   = beat_valid && !id_ok_c;
    resp_bad_c = beat_valid && id_ok_c && (rresp != RESP_OKAY);
    last_bad_c = beat_valid && id_ok_c && (rlast != last_beat);
    err_set_c  = write_reject || id_bad_c || resp_bad_c || last_bad_c;
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_err <= 1'b0;
    end else if (err_set_c) begin
      fill_err <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_axi_master.sv
// cache_fill_axi_master: turns one L1 instruction-cache miss into one
// line-aligned AXI4 INCR read burst and streams the beats back to the cache
// as single-cycle I_wait=0 strobes. Read-only, one burst outstanding.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   I_req/I_addr/I_write     cache miss request (I_in, I_type unused)
//   I_out/I_wait             fill word and its one-cycle strobe (active low)
//   AR*                      AXI4 read-address channel (constant ID/LEN/SIZE/BURST)
//   R*                       AXI4 read-data channel
//   fill_err                 sticky protocol/response error
// Build option: define FILL_PERF_CNT_EN to add the fill_cnt / stall_cnt
// performance counters as extra outputs.
module cache_fill_axi_master
  import axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID        = 4'd0,
  parameter int unsigned BURST_LEN     = 4,
  parameter int unsigned LINE_OFF_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  input  logic        I_write,
  input  logic [31:0] I_in,
  input  logic [2:0]  I_type,
  output logic [31:0] I_out,
  output logic        I_wait,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        fill_err
`ifdef FILL_PERF_CNT_EN
  ,
  output logic [31:0] fill_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  fill_state_t      state_q;
  fill_state_t      state_d;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;
  logic [31:0]      araddr_q;
  logic [31:0]      araddr_d;
  logic             write_reject_c;
  logic             beat_valid_c;
  logic             beat_fwd_c;
  logic             last_beat_c;

  // Inputs the engine deliberately ignores (word-only, read-only, line-aligned).
  logic unused_inputs;
  assign unused_inputs = ^{I_in, I_type, I_addr[LINE_OFF_BITS-1:0]};

  // Beat acceptance; rst masks it so the cache sees nothing during reset.
  always_comb begin
    beat_valid_c = (state_q == DATA) && RVALID && !rst;
    beat_fwd_c   = beat_valid_c && (RID == AXI_ID);
    last_beat_c  = (beat_cnt_q == LAST_BEAT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      araddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      araddr_q   <= araddr_d;
    end
  end

  // Next-state logic. I_req is only looked at in IDLE, so a request dropped
  // mid-burst is ignored and the line still completes.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    araddr_d       = araddr_q;
    write_reject_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_req) begin
          if (I_write) begin
            write_reject_c = 1'b1;
          end else begin
            araddr_d   = {I_addr[31:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
            beat_cnt_d = '0;
            state_d    = ADDR;
          end
        end
      end
      ADDR: begin
        if (ARREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // The burst ends on beat count; RLAST is only checked, never trusted.
        if (beat_fwd_c) begin
          if (last_beat_c) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Channel outputs; handshake enables are dropped as soon as rst is seen.
  always_comb begin
    ARID    = AXI_ID;
    ARADDR  = araddr_q;
    ARLEN   = 4'(BURST_LEN - 1);
    ARSIZE  = SIZE_WORD;
    ARBURST = BURST_INCR;
    ARVALID = (state_q == ADDR) && !rst;
    RREADY  = (state_q == DATA) && !rst;
    I_wait  = !beat_fwd_c;
    I_out   = beat_fwd_c ? RDATA : 32'd0;
  end

  fill_beat_checker #(
    .AXI_ID(AXI_ID)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .write_reject(write_reject_c),
    .beat_valid  (beat_valid_c),
    .last_beat   (last_beat_c),
    .rid         (RID),
    .rresp       (RRESP),
    .rlast       (RLAST),
    .fill_err    (fill_err)
  );

`ifdef FILL_PERF_CNT_EN
  // Completed line fills and busy (non-IDLE) cycles, both free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (state_q != IDLE) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (beat_fwd_c && last_beat_c) begin
        fill_cnt <= fill_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_axi_master.sv
// Testbench for cache_fill_axi_master: an AXI slave driver issues line fills
// and pushes the expected address and forwarded words into queues; a
// negedge monitor pops and compares whenever the DUT presents a beat or an
// address handshake. The expected error flag is derived from the injected
// faults of each fill.
module tb_cache_fill_axi_master;

  localparam int         BL = 4;
  localparam logic [3:0] ID = 4'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_in;
  logic [2:0]  I_type;
  logic [31:0] I_out;
  logic        I_wait;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        fill_err;
`ifdef FILL_PERF_CNT_EN
  logic [31:0] fill_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_ar_q[$];
  logic        err_exp;

  cache_fill_axi_master #(
    .AXI_ID(ID),
    .BURST_LEN(BL),
    .LINE_OFF_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .fill_err(fill_err)
`ifdef FILL_PERF_CNT_EN
    , .fill_cnt(fill_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: every I_wait=0 cycle and every AR handshake is checked against the queues.
  always @(negedge clk) begin
    if (!I_wait) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_beat", I_out, 32'hxxxx_xxxx);
      end else begin
        chk("fill_word", I_out, exp_data_q.pop_front());
      end
    end
    if (ARVALID && ARREADY) begin
      if (exp_ar_q.size() == 0) begin
        chk("unexpected_ar", ARADDR, 32'hxxxx_xxxx);
      end else begin
        chk("araddr", ARADDR, exp_ar_q.pop_front());
      end
      chk("arlen", 32'(ARLEN), 32'(BL - 1));
      chk("arsize", 32'(ARSIZE), 32'd2);
      chk("arburst", 32'(ARBURST), 32'd1);
      chk("arid", 32'(ARID), 32'(ID));
    end
  end

  // One line fill as seen from the cache and the AXI slave, with optional faults.
  task automatic run_fill(input logic [31:0] addr, input int ar_delay, input bit gap,
                          input bit fixed, input bit resp_err, input bit last_early,
                          input bit last_missing, input bit bad_rid, input int abort_after);
    int n;
    logic [31:0] a0;
    logic [31:0] d;
    @(posedge clk); #1;
    I_req   = 1'b1;
    I_write = 1'b0;
    I_addr  = addr;
    ARREADY = (ar_delay == 0);
    exp_ar_q.push_back(addr & ~32'(BL * 4 - 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ARVALID && n < 20);
    if (!ARVALID) begin
      chk1("arvalid_timeout", ARVALID, 1'b1);
      I_req = 1'b0;
      ARREADY = 1'b0;
      return;
    end
    a0 = ARADDR;
    if (ar_delay > 0) begin
      repeat (ar_delay) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk1("arvalid_hold", ARVALID, 1'b1);
        chk("araddr_stable", ARADDR, a0);
      end
      @(posedge clk); #1;
      ARREADY = 1'b1;
    end
    @(posedge clk); #1;
    ARREADY = 1'b0;
    for (int i = 0; i < BL; i++) begin
      if (abort_after > 0 && i == abort_after) begin
        RVALID = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        I_req = 1'b0;
        @(negedge clk);
        chk1("abort_arvalid", ARVALID, 1'b0);
        chk1("abort_rready", RREADY, 1'b0);
        chk1("abort_iwait", I_wait, 1'b1);
        chk1("abort_fill_err", fill_err, 1'b0);
        chk("abort_beats_left", 32'(exp_data_q.size()), 32'd0);
        err_exp = 1'b0;
        return;
      end
      if (gap) begin
        RVALID = 1'b0;
        @(posedge clk); #1;
      end
      if (bad_rid && i == 1) begin
        RVALID = 1'b1;
        RID    = ID ^ 4'h5;
        RDATA  = $urandom;
        RRESP  = 2'b00;
        RLAST  = 1'b0;
        @(posedge clk); #1;
      end
      d = fixed ? (32'hA0 + 32'(i)) : $urandom;
      RVALID = 1'b1;
      RID    = ID;
      RDATA  = d;
      RRESP  = (resp_err && i == 1) ? 2'b10 : 2'b00;
      RLAST  = (i == BL - 1) ? !last_missing : (last_early && i == BL - 2);
      exp_data_q.push_back(d);
      @(posedge clk); #1;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    I_req  = 1'b0;
    err_exp = err_exp | resp_err | last_early | last_missing | bad_rid;
    @(negedge clk);
    chk1("idle_rready", RREADY, 1'b0);
    chk1("idle_arvalid", ARVALID, 1'b0);
    chk1("idle_iwait", I_wait, 1'b1);
    chk1("fill_err", fill_err, err_exp);
    chk("beats_left", 32'(exp_data_q.size()), 32'd0);
    chk("ar_left", 32'(exp_ar_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    err_exp = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    I_req = 1'b0; I_addr = 32'd0; I_write = 1'b0; I_in = 32'd0; I_type = 3'b010;
    ARREADY = 1'b0; RID = ID; RDATA = 32'd0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    err_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_arvalid", ARVALID, 1'b0);
    chk1("rst_rready", RREADY, 1'b0);
    chk1("rst_iwait", I_wait, 1'b1);
    chk("rst_iout", I_out, 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk1("rst_fill_err", fill_err, 1'b0);

`ifdef FILL_PERF_CNT_EN
    repeat (3) run_fill($urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("fill_cnt", fill_cnt, 32'd3);
    chk("stall_cnt", stall_cnt, 32'd3 * (1 + BL));
`endif

    // Directed line fill, stalled address phase, toggling RVALID.
    run_fill(32'h0000_1238, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_fill($urandom, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_fill($urandom, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized clean fills.
    for (int k = 0; k < 8; k++) begin
      run_fill($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    // Error response on beat 2 plus early RLAST on beat 3.
    run_fill($urandom, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // Reset mid-burst, then a full refill.
    run_fill($urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_fill($urandom, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Foreign RID beat is swallowed.
    run_fill($urandom, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    do_reset();
    // Missing RLAST on the final beat.
    run_fill($urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_reset();

    // Write requests are rejected and never reach AXI.
    @(posedge clk); #1;
    I_req = 1'b1;
    I_write = 1'b1;
    I_addr = $urandom;
    repeat (3) begin
      @(negedge clk);
      chk1("wr_arvalid", ARVALID, 1'b0);
      chk1("wr_iwait", I_wait, 1'b1);
    end
    @(posedge clk); #1;
    I_req = 1'b0;
    I_write = 1'b0;
    @(negedge clk);
    chk1("wr_fill_err", fill_err, 1'b1);
    chk1("wr_arvalid_after", ARVALID, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
